// File: rtl/ws2811_pkg.sv
// Shared WS2811 line constants and decoder/encoder state encoding.
package ws2811_pkg;

   localparam int SEGMENT_CLOCKS = 4;
   localparam int BIT_CLOCKS     = 16;
   localparam int BITS_PER_LED   = 24;
   localparam int MAX_LEDS       = 150;
   localparam int LATCH_LOW      = 600;

   typedef enum logic [1:0] {
      WAIT_LATCH = 2'd0,
      IDLE       = 2'd1,
      HIGH       = 2'd2,
      LOW        = 2'd3
   } ws_state_e;

   // Pixel words arrive MSB first, so each new bit enters at the LSB.
   function automatic logic [BITS_PER_LED-1:0] shift_in_msb(
      input logic [BITS_PER_LED-1:0] word,
      input logic                    bit_val
   );
      return {word[BITS_PER_LED-2:0], bit_val};
   endfunction

endpackage

// File: rtl/ws2811_decoder_if.sv
// Pixel-stream bundle between a WS2811 line decoder (slave) and its consumer (master).
interface ws2811_decoder_if;
   logic        data_in;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic [7:0]  pixel_index;
   logic        frame_done;
   logic [7:0]  led_count;
   logic        error;
   logic        busy;

   modport master (
      output data_in,
      input  pixel_data, pixel_valid, pixel_index, frame_done, led_count, error, busy
   );

   modport slave (
      input  data_in,
      output pixel_data, pixel_valid, pixel_index, frame_done, led_count, error, busy
   );
endinterface

// File: rtl/ws2811_decoder_input_synchronizer.sv
// Two-flop synchronizer for an asynchronous serial pin, with rise/fall strobes
// taken between the synchronized level and its one-cycle-delayed copy.
module ws2811_decoder_input_synchronizer (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2811_decoder.sv
// WS2811 one-wire decoder: measures high-pulse lengths into bits, packs 24-bit
// pixel words and reports frame boundaries on a long low (latch).
module ws2811_decoder #(
   parameter int BIT_THRESHOLD = 8,
   parameter int MIN_HIGH      = 2,
   parameter int MAX_HIGH      = 15,
   parameter int LATCH_LOW     = ws2811_pkg::LATCH_LOW,
   parameter int BITS_PER_LED  = ws2811_pkg::BITS_PER_LED,
   parameter int MAX_LEDS      = ws2811_pkg::MAX_LEDS
) (
   input  logic              clock_12mhz,
   input  logic              reset,
   ws2811_decoder_if.slave   bus
);
   import ws2811_pkg::*;

   localparam int HC_W = $clog2(MAX_HIGH + 2);
   localparam int LC_W = $clog2(LATCH_LOW + 1);
   localparam logic [HC_W-1:0] HC_SAT  = HC_W'(MAX_HIGH + 1);
   localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_HIGH);
   localparam logic [HC_W-1:0] HC_MIN  = HC_W'(MIN_HIGH);
   localparam logic [HC_W-1:0] HC_ONE  = HC_W'(BIT_THRESHOLD);
   localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATCH_LOW - 1);
   localparam logic [4:0]      BC_LAST = 5'(BITS_PER_LED - 1);
   localparam logic [7:0]      PIX_CAP = 8'(MAX_LEDS);

   logic level_s, rise_s, fall_s;

   ws2811_decoder_input_synchronizer u_sync (
      .clk_i  (clock_12mhz),
      .rst_i  (reset),
      .din_i  (bus.data_in),
      .level_o(level_s),
      .rise_o (rise_s),
      .fall_o (fall_s)
   );

   ws_state_e   state_q, state_d;
   logic [HC_W-1:0] high_cnt_q, high_cnt_d;
   logic [LC_W-1:0] low_cnt_q, low_cnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [7:0]  pix_next_q, pix_next_d;
   logic        ovf_seen_q, ovf_seen_d;
   logic [23:0] pixel_data_q, pixel_data_d;
   logic [7:0]  pixel_index_q, pixel_index_d;
   logic [7:0]  led_count_q, led_count_d;
   logic        pixel_valid_q, pixel_valid_d;
   logic        frame_done_q, frame_done_d;
   logic        error_q, error_d;
   logic        busy_q, busy_d;

   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         state_q       <= WAIT_LATCH;
         high_cnt_q    <= '0;
         low_cnt_q     <= '0;
         bit_cnt_q     <= 5'd0;
         shift_q       <= 24'd0;
         pix_next_q    <= 8'd0;
         ovf_seen_q    <= 1'b0;
         pixel_data_q  <= 24'd0;
         pixel_index_q <= 8'd0;
         led_count_q   <= 8'd0;
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         error_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         high_cnt_q    <= high_cnt_d;
         low_cnt_q     <= low_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         pix_next_q    <= pix_next_d;
         ovf_seen_q    <= ovf_seen_d;
         pixel_data_q  <= pixel_data_d;
         pixel_index_q <= pixel_index_d;
         led_count_q   <= led_count_d;
         pixel_valid_q <= pixel_valid_d;
         frame_done_q  <= frame_done_d;
         error_q       <= error_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      high_cnt_d    = high_cnt_q;
      low_cnt_d     = low_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      pix_next_d    = pix_next_q;
      ovf_seen_d    = ovf_seen_q;
      pixel_data_d  = pixel_data_q;
      pixel_index_d = pixel_index_q;
      led_count_d   = led_count_q;
      busy_d        = busy_q;
      pixel_valid_d = 1'b0;
      frame_done_d  = 1'b0;
      error_d       = 1'b0;

      case (state_q)
         WAIT_LATCH: begin
            if (level_s) begin
               low_cnt_d = '0;
            end else if (low_cnt_q == LC_LAST) begin
               low_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               low_cnt_d = low_cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (rise_s) begin
               high_cnt_d = HC_W'(1);
               busy_d     = 1'b1;
               state_d    = HIGH;
            end else begin
               low_cnt_d = '0;
            end
         end
         HIGH: begin
            if (high_cnt_q > HC_MAX) begin
               // Over-long pulse: the whole frame is untrusted, requalify on a latch.
               error_d    = 1'b1;
               busy_d     = 1'b0;
               low_cnt_d  = '0;
               bit_cnt_d  = 5'd0;
               pix_next_d = 8'd0;
               ovf_seen_d = 1'b0;
               state_d    = WAIT_LATCH;
            end else if (fall_s) begin
               low_cnt_d = LC_W'(1);
               state_d   = LOW;
               if (high_cnt_q < HC_MIN) begin
                  error_d = 1'b1;
               end else begin
                  shift_d = shift_in_msb(shift_q, high_cnt_q >= HC_ONE);
                  if (bit_cnt_q == BC_LAST) begin
                     bit_cnt_d = 5'd0;
                     if (pix_next_q < PIX_CAP) begin
                        pixel_data_d  = shift_d;
                        pixel_index_d = pix_next_q;
                        pixel_valid_d = 1'b1;
                        pix_next_d    = pix_next_q + 8'd1;
                     end else begin
                        error_d    = ~ovf_seen_q;
                        ovf_seen_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else if (high_cnt_q != HC_SAT) begin
               high_cnt_d = high_cnt_q + 1'b1;
            end else begin
               high_cnt_d = high_cnt_q;
            end
         end
         LOW: begin
            if (rise_s) begin
               high_cnt_d = HC_W'(1);
               state_d    = HIGH;
            end else if (low_cnt_q == LC_LAST) begin
               frame_done_d = 1'b1;
               led_count_d  = pix_next_q;
               error_d      = (bit_cnt_q != 5'd0);
               pix_next_d   = 8'd0;
               bit_cnt_d    = 5'd0;
               ovf_seen_d   = 1'b0;
               low_cnt_d    = '0;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end else begin
               low_cnt_d = low_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LATCH;
         end
      endcase
   end

   assign bus.pixel_data  = pixel_data_q;
   assign bus.pixel_valid = pixel_valid_q;
   assign bus.pixel_index = pixel_index_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.led_count   = led_count_q;
   assign bus.error       = error_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ws2811_decoder.sv
// Directed bench for ws2811_decoder: drives WS2811 waveforms and checks
// pixel words, indices, frame boundaries and error pulses against fixed values.
module tb_ws2811_decoder;

   logic clk;
   logic rst;

   ws2811_decoder_if bus ();

   ws2811_decoder dut (
      .clock_12mhz(clk),
      .reset      (rst),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int valid_cnt  = 0;
   int fd_cnt     = 0;
   int err_cnt    = 0;
   int fd_err_cnt = 0;
   logic [23:0] log_data [0:255];
   logic [7:0]  log_idx  [0:255];

   // Output pulse monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.pixel_valid) begin
            if (valid_cnt < 256) begin
               log_data[valid_cnt] = bus.pixel_data;
               log_idx[valid_cnt]  = bus.pixel_index;
            end
            valid_cnt = valid_cnt + 1;
         end
         if (bus.frame_done) fd_cnt = fd_cnt + 1;
         if (bus.error) err_cnt = err_cnt + 1;
         if (bus.frame_done && bus.error) fd_err_cnt = fd_err_cnt + 1;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   task automatic clear_mon();
      valid_cnt  = 0;
      fd_cnt     = 0;
      err_cnt    = 0;
      fd_err_cnt = 0;
   endtask

   task automatic send_pulse(input int h, input int l);
      bus.data_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.data_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) send_pulse(12, 4);
      else   send_pulse(4, 12);
   endtask

   task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(w[i]);
   endtask

   task automatic hold_low(input int n);
      bus.data_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int bad;
      logic [23:0] w;

      bus.data_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
      chk_eq("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
      chk_eq("rst_pixel_index", 32'(bus.pixel_index), 32'd0);
      chk_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
      chk_eq("rst_led_count", 32'(bus.led_count), 32'd0);
      chk_eq("rst_error", 32'(bus.error), 32'd0);
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Latch qualification: pulses before 600 low clocks are ignored.
      clear_mon();
      send_pulse(12, 20);
      send_pulse(4, 20);
      chk_eq("prelatch_busy", 32'(bus.busy), 32'd0);
      chk_eq("prelatch_valid", 32'(valid_cnt), 32'd0);
      chk_eq("prelatch_err", 32'(err_cnt), 32'd0);
      hold_low(620);

      // Single pixel 0xA5C3F0; first bit sent by hand to observe busy.
      clear_mon();
      w = 24'hA5C3F0;
      bus.data_in = 1'b1;
      repeat (12) @(negedge clk);
      chk_eq("first_rise_busy", 32'(bus.busy), 32'd1);
      bus.data_in = 1'b0;
      repeat (4) @(negedge clk);
      send_bits(w, 22, 0);
      hold_low(620);
      chk_eq("px1_valid_cnt", 32'(valid_cnt), 32'd1);
      chk_eq("px1_data", 32'(log_data[0]), 32'h00A5C3F0);
      chk_eq("px1_index", 32'(log_idx[0]), 32'd0);
      chk_eq("px1_frame_done", 32'(fd_cnt), 32'd1);
      chk_eq("px1_led_count", 32'(bus.led_count), 32'd1);
      chk_eq("px1_err", 32'(err_cnt), 32'd0);
      chk_eq("px1_busy_after", 32'(bus.busy), 32'd0);

      // Full frame plus one overflow word.
      clear_mon();
      for (int p = 0; p < 151; p++) begin
         w = 24'h100000 + 24'(p);
         send_bits(w, 23, 0);
      end
      chk_eq("full_err_before_latch", 32'(err_cnt), 32'd1);
      chk_eq("full_valid_before_latch", 32'(valid_cnt), 32'd150);
      hold_low(620);
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         if (log_idx[i] !== 8'(i) || log_data[i] !== 24'h100000 + 24'(i)) bad++;
      end
      chk_eq("full_seq_bad", 32'(bad), 32'd0);
      chk_eq("full_last_index", 32'(log_idx[149]), 32'd149);
      chk_eq("full_valid_cnt", 32'(valid_cnt), 32'd150);
      chk_eq("full_err_cnt", 32'(err_cnt), 32'd1);
      chk_eq("full_frame_done", 32'(fd_cnt), 32'd1);
      chk_eq("full_led_count", 32'(bus.led_count), 32'd150);

      // Thresholds: 1 glitch, 7 -> 0, 8 -> 1, then 22 bits completing 0x6AAAAA.
      clear_mon();
      send_pulse(1, 12);
      chk_eq("glitch_err", 32'(err_cnt), 32'd1);
      send_pulse(7, 9);
      send_pulse(8, 8);
      w = 24'h2AAAAA;
      send_bits(w, 21, 0);
      chk_eq("thr_valid_cnt", 32'(valid_cnt), 32'd1);
      chk_eq("thr_data", 32'(log_data[0]), 32'h006AAAAA);
      send_pulse(16, 20);
      chk_eq("long_err", 32'(err_cnt), 32'd2);
      chk_eq("long_busy", 32'(bus.busy), 32'd0);
      w = 24'h654321;
      send_bits(w, 23, 0);
      hold_low(620);
      chk_eq("long_ignored_valid", 32'(valid_cnt), 32'd1);
      chk_eq("long_no_frame_done", 32'(fd_cnt), 32'd0);
      w = 24'h123456;
      send_bits(w, 23, 0);
      hold_low(620);
      chk_eq("requal_valid_cnt", 32'(valid_cnt), 32'd2);
      chk_eq("requal_data", 32'(log_data[1]), 32'h00123456);
      chk_eq("requal_index", 32'(log_idx[1]), 32'd0);
      chk_eq("requal_led_count", 32'(bus.led_count), 32'd1);

      // Reset mid-frame after 12 bits.
      clear_mon();
      w = 24'hFFF000;
      send_bits(w, 23, 12);
      rst = 1'b1;
      @(negedge clk);
      chk_eq("midrst_busy", 32'(bus.busy), 32'd0);
      chk_eq("midrst_led_count", 32'(bus.led_count), 32'd0);
      chk_eq("midrst_pixel_data", 32'(bus.pixel_data), 32'd0);
      rst = 1'b0;
      w = 24'h0F0F0F;
      send_bits(w, 23, 0);
      hold_low(100);
      chk_eq("midrst_no_pulses", 32'(valid_cnt + fd_cnt + err_cnt), 32'd0);
      hold_low(620);
      w = 24'hC0FFEE;
      send_bits(w, 23, 0);
      hold_low(620);
      chk_eq("postrst_valid_cnt", 32'(valid_cnt), 32'd1);
      chk_eq("postrst_data", 32'(log_data[0]), 32'h00C0FFEE);
      chk_eq("postrst_index", 32'(log_idx[0]), 32'd0);

      // Partial word: 10 bits then latch.
      clear_mon();
      w = 24'hB40000;
      send_bits(w, 23, 14);
      hold_low(620);
      chk_eq("partial_frame_done", 32'(fd_cnt), 32'd1);
      chk_eq("partial_fd_with_err", 32'(fd_err_cnt), 32'd1);
      chk_eq("partial_err_cnt", 32'(err_cnt), 32'd1);
      chk_eq("partial_valid_cnt", 32'(valid_cnt), 32'd0);
      chk_eq("partial_led_count", 32'(bus.led_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
